// File: rtl/arcade_audio_pkg.sv
// Shared types, constants and gain-ramp helpers for the arcade filter sequencer.
package arcade_audio_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FADE_OUT = 3'd1,
        SWITCH   = 3'd2,
        SETTLE   = 3'd3,
        FADE_IN  = 3'd4
    } flt_seq_state_t;

    localparam logic [8:0] GAIN_UNITY      = 9'd256;
    localparam logic [3:0] FLT_SEL_DEFAULT = 4'd0;

    // Fade-out step, clamped at silence.
    function automatic logic [8:0] gain_step_down(input logic [8:0] g, input logic [8:0] step);
        logic [8:0] res;
        if (g > step) begin
            res = g - step;
        end else begin
            res = 9'd0;
        end
        return res;
    endfunction

    // Fade-in step, clamped at unity; the sum is widened so it cannot wrap.
    function automatic logic [8:0] gain_step_up(input logic [8:0] g, input logic [8:0] step);
        logic [9:0] sum;
        logic [8:0] res;
        sum = {1'b0, g} + {1'b0, step};
        if (sum >= {1'b0, GAIN_UNITY}) begin
            res = GAIN_UNITY;
        end else begin
            res = sum[8:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_gain_stage.sv
// One audio channel: signed sample times unsigned Q8 gain, registered on the sample strobe.
module audio_gain_stage (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_ce,
    input  logic signed [15:0] audio_in,
    input  logic        [8:0]  gain,
    output logic signed [15:0] audio_out
);

    logic signed [9:0]  gain_op;
    logic signed [24:0] prod;

    // Gain never exceeds 256, so the 25-bit product and 16-bit result cannot overflow.
    assign gain_op = $signed({1'b0, gain});
    assign prod    = 25'(audio_in) * 25'(gain_op);

    // Output register, holds between sample strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_out <= 16'sd0;
        end else if (sample_ce) begin
            audio_out <= 16'(prod >>> 8);
        end else begin
            audio_out <= audio_out;
        end
    end

endmodule

// File: rtl/arcade_filter_sequencer.sv
// Debounces the filter switch and sequences fade-out, coefficient reload, settle and fade-in
// so that low-pass filter changes are glitch-free on the audio path.
module arcade_filter_sequencer #(
    parameter int DEBOUNCE_SAMPLES = 64,
    parameter int SETTLE_SAMPLES   = 256,
    parameter int RAMP_STEP        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_ce,
    input  logic        [3:0]  afilter_sw,
    input  logic signed [15:0] audio_in_l,
    input  logic signed [15:0] audio_in_r,
    output logic        [3:0]  flt_sel,
    output logic               cfg_load,
    output logic signed [15:0] audio_out_l,
    output logic signed [15:0] audio_out_r,
    output logic        [8:0]  gain,
    output logic               busy
);
    import arcade_audio_pkg::*;

    localparam logic [9:0]  DB_MAX      = 10'(DEBOUNCE_SAMPLES);
    localparam logic [11:0] SETTLE_LOAD = 12'(SETTLE_SAMPLES);
    localparam logic [8:0]  STEP        = 9'(RAMP_STEP);

    flt_seq_state_t state, state_nx;
    logic [3:0]  sw_q, sw_cand;
    logic [9:0]  db_cnt;
    logic        change_req;
    logic [1:0]  wcnt, wcnt_nx;
    logic [11:0] scnt, scnt_nx;
    logic [8:0]  gain_nx, ramp_dn, ramp_up;
    logic [3:0]  flt_sel_nx;
    logic        cfg_load_nx;

    // Switch input register and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_q    <= 4'd0;
            sw_cand <= 4'd0;
            db_cnt  <= 10'd0;
        end else begin
            sw_q <= afilter_sw;
            if (sw_q != sw_cand) begin
                sw_cand <= sw_q;
                db_cnt  <= 10'd0;
            end else if (sample_ce && (db_cnt < DB_MAX)) begin
                db_cnt <= db_cnt + 10'd1;
            end else begin
                db_cnt <= db_cnt;
            end
        end
    end

    assign change_req = (db_cnt == DB_MAX) && (sw_cand != flt_sel);
    assign ramp_dn    = gain_step_down(gain, STEP);
    assign ramp_up    = gain_step_up(gain, STEP);

    // Sequencer next-state, gain ramp and counter control.
    always_comb begin
        state_nx    = state;
        gain_nx     = gain;
        flt_sel_nx  = flt_sel;
        cfg_load_nx = 1'b0;
        wcnt_nx     = wcnt;
        scnt_nx     = scnt;
        case (state)
            IDLE: begin
                gain_nx = GAIN_UNITY;
                if (change_req) begin
                    state_nx = FADE_OUT;
                end else begin
                    state_nx = IDLE;
                end
            end
            FADE_OUT: begin
                if (sample_ce) begin
                    gain_nx = ramp_dn;
                end else begin
                    gain_nx = gain;
                end
                // Retarget on the way into SWITCH so flt_sel leads cfg_load by three clocks.
                if ((gain == 9'd0) || (sample_ce && (ramp_dn == 9'd0))) begin
                    state_nx   = SWITCH;
                    flt_sel_nx = sw_cand;
                    wcnt_nx    = 2'd0;
                end else begin
                    state_nx = FADE_OUT;
                end
            end
            SWITCH: begin
                gain_nx = 9'd0;
                if (wcnt == 2'd2) begin
                    cfg_load_nx = 1'b1;
                    scnt_nx     = SETTLE_LOAD;
                    state_nx    = SETTLE;
                end else begin
                    wcnt_nx  = wcnt + 2'd1;
                    state_nx = SWITCH;
                end
            end
            SETTLE: begin
                gain_nx = 9'd0;
                if (scnt == 12'd0) begin
                    state_nx = FADE_IN;
                end else if (sample_ce) begin
                    scnt_nx = scnt - 12'd1;
                    if (scnt == 12'd1) begin
                        state_nx = FADE_IN;
                    end else begin
                        state_nx = SETTLE;
                    end
                end else begin
                    state_nx = SETTLE;
                end
            end
            FADE_IN: begin
                if (change_req) begin
                    state_nx = FADE_OUT;
                end else if (sample_ce) begin
                    gain_nx = ramp_up;
                    if (ramp_up == GAIN_UNITY) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = FADE_IN;
                    end
                end else begin
                    state_nx = FADE_IN;
                end
            end
            default: begin
                state_nx = SWITCH;
                gain_nx  = 9'd0;
                wcnt_nx  = 2'd0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SWITCH;
            gain     <= 9'd0;
            flt_sel  <= FLT_SEL_DEFAULT;
            cfg_load <= 1'b0;
            wcnt     <= 2'd0;
            scnt     <= 12'd0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nx;
            gain     <= gain_nx;
            flt_sel  <= flt_sel_nx;
            cfg_load <= cfg_load_nx;
            wcnt     <= wcnt_nx;
            scnt     <= scnt_nx;
            busy     <= (state_nx != IDLE);
        end
    end

    audio_gain_stage u_gain_l (
        .clk       (clk),
        .reset     (reset),
        .sample_ce (sample_ce),
        .audio_in  (audio_in_l),
        .gain      (gain),
        .audio_out (audio_out_l)
    );

    audio_gain_stage u_gain_r (
        .clk       (clk),
        .reset     (reset),
        .sample_ce (sample_ce),
        .audio_in  (audio_in_r),
        .gain      (gain),
        .audio_out (audio_out_r)
    );

endmodule

// File: tb/tb_arcade_filter_sequencer.sv
// Randomized bench for arcade_filter_sequencer; expected gain is a closed-form schedule
// indexed by sample number, expected audio is plain integer scaling.
module tb_arcade_filter_sequencer;

    localparam int D    = 64;
    localparam int S    = 256;
    localparam int STEP = 8;
    localparam int N    = (256 + STEP - 1) / STEP;
    localparam int FULL = D + N + S + N + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_ce;
    logic        [3:0]  afilter_sw;
    logic signed [15:0] audio_in_l, audio_in_r;
    logic        [3:0]  flt_sel;
    logic               cfg_load;
    logic signed [15:0] audio_out_l, audio_out_r;
    logic        [8:0]  gain;
    logic               busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0, cfg_count = 0, cfg_cyc = 0, flt_cyc = 0;
    logic [3:0] cfg_flt = 4'd0, flt_prev = 4'd0;
    logic       fixed_l_en;
    logic [15:0] fixed_l;

    arcade_filter_sequencer dut (
        .clk(clk), .reset(reset), .sample_ce(sample_ce), .afilter_sw(afilter_sw),
        .audio_in_l(audio_in_l), .audio_in_r(audio_in_r), .flt_sel(flt_sel),
        .cfg_load(cfg_load), .audio_out_l(audio_out_l), .audio_out_r(audio_out_r),
        .gain(gain), .busy(busy)
    );

    always #5 clk = ~clk;

    // Records when flt_sel last moved and when each cfg_load pulse was seen.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cfg_load === 1'b1) begin
            cfg_count <= cfg_count + 1;
            cfg_cyc   <= cyc;
            cfg_flt   <= flt_sel;
        end
        if (flt_sel !== flt_prev) flt_cyc <= cyc;
        flt_prev <= flt_sel;
    end

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Gain used by the i-th sample strobe counted from a stable switch change in IDLE.
    function automatic int exp_gain(input int i);
        int g;
        if (i <= D + 1)              g = 256;
        else if (i <= D + N)         g = 256 - STEP * (i - D - 1);
        else if (i <= D + N + S)     g = 0;
        else if (i <= D + N + S + N) g = STEP * (i - D - N - S - 1);
        else                         g = 256;
        if (g < 0)   g = 0;
        if (g > 256) g = 256;
        return g;
    endfunction

    function automatic logic [31:0] scale(input logic [15:0] x, input int g);
        int p;
        p = int'($signed(x)) * g;
        p = p >>> 8;
        return {16'd0, p[15:0]};
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] v;
        do v = 4'($urandom); while (v == a || v == b);
        return v;
    endfunction

    // One sample strobe every four clocks; optionally checks gain and both outputs.
    task automatic strobe(input int exp_g, input bit do_check);
        logic [15:0] l, r;
        l = fixed_l_en ? fixed_l : 16'($urandom);
        r = 16'($urandom);
        @(negedge clk);
        sample_ce = 1'b1;
        audio_in_l = l;
        audio_in_r = r;
        if (do_check) check_val("gain", {23'd0, gain}, exp_g);
        @(negedge clk);
        sample_ce = 1'b0;
        if (do_check) begin
            check_val("out_l", {16'd0, audio_out_l}, scale(l, exp_g));
            check_val("out_r", {16'd0, audio_out_r}, scale(r, exp_g));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_sw(input logic [3:0] v);
        afilter_sw = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_cfg_after(input int lat, input string tag);
        int t_hit;
        t_hit = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (cfg_load === 1'b1 && t_hit == 0) t_hit = t;
        end
        check_val(tag, t_hit, lat);
    endtask

    task automatic run_until_sel(input logic [3:0] sel, input string tag);
        int n;
        n = 0;
        while (!(flt_sel == sel && busy == 1'b0) && n < 2000) begin
            strobe(0, 1'b0);
            n++;
        end
        check_val({tag, "_done"}, (n < 2000), 1);
        check_val({tag, "_gain"}, {23'd0, gain}, 256);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_sel"},  {28'd0, flt_sel}, 0);
        check_val({tag, "_gain"}, {23'd0, gain}, 0);
        check_val({tag, "_cfg"},  {31'd0, cfg_load}, 0);
        check_val({tag, "_l"},    {16'd0, audio_out_l}, 0);
        check_val({tag, "_r"},    {16'd0, audio_out_r}, 0);
        check_val({tag, "_busy"}, {31'd0, busy}, 1);
    endtask

    initial begin
        logic [3:0] a, b, cur;
        int base, nt;
        reset = 1'b1; sample_ce = 1'b0; afilter_sw = 4'd0;
        audio_in_l = 16'sd0; audio_in_r = 16'sd0; fixed_l_en = 1'b0; fixed_l = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Power-up: reload of filter 0, settle, fade in.
        reset = 1'b0;
        expect_cfg_after(3, "pwr_cfg_lat");
        for (int i = D + N + 1; i <= FULL; i++) strobe(exp_gain(i), 1'b1);
        #1;
        check_val("pwr_busy", {31'd0, busy}, 0);
        check_val("pwr_cfgs", cfg_count, 1);
        check_val("pwr_sel", {28'd0, flt_sel}, 0);

        // Full change to filter 4 with a fixed left sample.
        fixed_l_en = 1'b1; fixed_l = 16'h4000;
        set_sw(4'd4);
        for (int i = 1; i <= FULL; i++) strobe(exp_gain(i), 1'b1);
        fixed_l_en = 1'b0;
        #1;
        check_val("chg_sel", {28'd0, flt_sel}, 4);
        check_val("chg_cfgs", cfg_count, 2);
        check_val("chg_cfg_sel", {28'd0, cfg_flt}, 4);
        check_val("chg_cfg_lat", cfg_cyc - flt_cyc, 3);
        check_val("chg_busy", {31'd0, busy}, 0);

        // Short glitches on the switch never start a sequence.
        for (int t = 0; t < 3; t++) begin
            cur = flt_sel;
            base = cfg_count;
            set_sw(pick(cur, cur));
            nt = $urandom_range(1, 10);
            for (int k = 0; k < nt; k++) strobe(256, 1'b1);
            set_sw(cur);
            for (int k = 0; k < D + 6; k++) strobe(256, 1'b1);
            #1;
            check_val("glitch_cfgs", cfg_count, base);
            check_val("glitch_busy", {31'd0, busy}, 0);
        end

        // Second request during SETTLE: first sequence finishes, then retargets.
        a = pick(flt_sel, flt_sel);
        b = pick(a, flt_sel);
        base = cfg_count;
        set_sw(a);
        for (int i = 1; i <= D + N + 10; i++) strobe(exp_gain(i), 1'b1);
        #1;
        check_val("two_cfgs1", cfg_count, base + 1);
        check_val("two_sel1", {28'd0, cfg_flt}, {28'd0, a});
        set_sw(b);
        run_until_sel(b, "two");
        #1;
        check_val("two_cfgs2", cfg_count, base + 2);
        check_val("two_sel2", {28'd0, cfg_flt}, {28'd0, b});
        check_val("two_cfg_lat", cfg_cyc - flt_cyc, 3);

        // Request lands mid fade-in at gain 128: fade-out resumes from there.
        a = pick(flt_sel, flt_sel);
        b = pick(a, flt_sel);
        base = cfg_count;
        set_sw(a);
        for (int i = 1; i < N + S + 17; i++) strobe(exp_gain(i), 1'b1);
        set_sw(b);
        for (int i = N + S + 17; i <= D + N + S + 16; i++) strobe(exp_gain(i), 1'b1);
        for (int j = 1; j <= 16; j++) strobe(128 - STEP * (j - 1), 1'b1);
        run_until_sel(b, "fin");
        #1;
        check_val("fin_cfgs", cfg_count, base + 2);
        check_val("fin_sel", {28'd0, cfg_flt}, {28'd0, b});

        // Reset during fade-out at gain 96, then restart from SWITCH.
        a = pick(flt_sel, 4'd0);
        set_sw(a);
        for (int i = 1; i <= D + 20; i++) strobe(exp_gain(i), 1'b1);
        check_val("pre_rst_gain", {23'd0, gain}, 96);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_rst");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("rst_no_cfg", {31'd0, cfg_load}, 0);
        end
        reset = 1'b0;
        expect_cfg_after(3, "rst_cfg_lat");
        #1;
        check_val("rst_cfg_sel", {28'd0, cfg_flt}, 0);
        run_until_sel(a, "rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arcade_filter_sequencer.md
# arcade_filter_sequencer

Sequences glitch-free changes of the arcade audio low-pass filter selection on the Pocket audio path. It debounces the user filter switch, fades the audio to silence, and retargets the coefficient table (`arcade_filters`) through `flt_sel`. It then pulses `cfg_load` so the IIR filter latches the new coefficients and clears its history, waits for the filter to settle, and fades back in. It sits between the core audio output and the IIR filter, in the `clk` domain.

## Interface
Parameters:
- `DEBOUNCE_SAMPLES`, 64: samples `afilter_sw` must be stable before acting (1..1023).
- `SETTLE_SAMPLES`, 256: silent samples after `cfg_load` (1..4095).
- `RAMP_STEP`, 8: gain change per sample during fades (1..256).

Ports:
- `clk`, in, 1: audio system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `sample_ce`, in, 1: one-cycle audio sample strobe.
- `afilter_sw`, in, 4: requested filter, synchronous to `clk`.
- `audio_in_l` / `audio_in_r`, in, 16 each: signed input samples, valid at `sample_ce`.
- `flt_sel`, out, 4: filter index driven to the coefficient table.
- `cfg_load`, out, 1: one-cycle pulse; the IIR filter latches coefficients and clears its state.
- `audio_out_l` / `audio_out_r`, out, 16 each: signed, gain-scaled samples.
- `gain`, out, 9: current gain, 0..256, where 256 is unity.
- `busy`, out, 1: high whenever the state is not `IDLE`.

## Operation
- The input is registered into `sw_q` every clk.
- Debounce: `sw_cand`/`db_cnt` (10-bit).
  - If `sw_q != sw_cand`: `sw_cand <= sw_q`, `db_cnt <= 0`.
  - Otherwise, on each `sample_ce`, `db_cnt` increments, saturating at `DEBOUNCE_SAMPLES`.
  - `change_req` = (`db_cnt == DEBOUNCE_SAMPLES`) and (`sw_cand != flt_sel`).
- States: `IDLE`, `FADE_OUT`, `SWITCH`, `SETTLE`, `FADE_IN`.
  - `IDLE`: `gain` = 256. On `change_req` go to `FADE_OUT`.
  - `FADE_OUT`: on each `sample_ce`, `gain <= max(gain - RAMP_STEP, 0)`. In the cycle `gain` reaches 0, go to `SWITCH`.
  - `SWITCH`:
    - On entry cycle: `flt_sel <= sw_cand` (the latest candidate, even if it changed during the fade) and `wcnt <= 0`.
    - `wcnt` counts 2 clk cycles to cover the coefficient table's register latency.
    - On the 3rd cycle, assert `cfg_load` for exactly one cycle, load `scnt <= SETTLE_SAMPLES`, and go to `SETTLE`.
  - `SETTLE`: `gain` = 0. Decrement `scnt` on `sample_ce`; at 0 go to `FADE_IN`.
  - `FADE_IN`:
    - On `sample_ce`: `gain <= min(gain + RAMP_STEP, 256)`. At 256, go to `IDLE`.
    - If `change_req` occurs, go to `FADE_OUT` immediately from the current gain, with no jump.
- Datapath, per channel, on `sample_ce`: `audio_out <= (audio_in * gain) >>> 8`.
  - The product is 25-bit signed; `gain` is zero-extended to a signed 10-bit operand.
  - Result is truncated to 16 bits; no overflow is possible since `gain` ≤ 256.
  - Outputs hold between strobes.
- A request for the already-active `flt_sel` never triggers a sequence.
- `afilter_sw` changes during `FADE_OUT`/`SWITCH`/`SETTLE` only update `sw_cand`. Any remaining mismatch re-triggers from `IDLE` or `FADE_IN`.

## Timing
- Reset values:
  - state = `SWITCH`; `flt_sel` = 0; `gain` = 0; `cfg_load` = 0; `audio_out_*` = 0; `busy` = 1.
  - `sw_q` = 0, `sw_cand` = 0, `db_cnt` = 0, `wcnt` = 0, `scnt` = 0.
- The first sequence after reset loads filter 0, settles, and fades in. The power-up result is silence, then a ramp.
- Reset asserted mid-sequence returns immediately to the reset values. No `cfg_load` is emitted during reset.
- Audio latency: 1 clk after `sample_ce`. The output uses the `gain` value present in the `sample_ce` cycle, before that cycle's ramp update.
- `cfg_load` occurs exactly 3 clk after `SWITCH` entry and ≥3 clk after `flt_sel` updates.
- Full change duration with N = ceil(256/`RAMP_STEP`):
  - Total = `DEBOUNCE_SAMPLES` + N + `SETTLE_SAMPLES` + N samples, plus 3 clk.
  - With defaults: 64 + 32 + 256 + 32 samples.
- A `sample_ce` arriving during `SWITCH` is ignored by the counters; audio is still processed at gain 0.

## Structure
- Package `arcade_audio_pkg`:
  - Typedef `flt_seq_state_t` (enum logic [2:0]).
  - Constants `GAIN_UNITY = 9'd256` and `FLT_SEL_DEFAULT = 4'd0`.
- One sub-module, `audio_gain_stage`: a per-channel signed multiply and register with `sample_ce`, instantiated twice.
- The FSM, debounce and counters stay in the top module.

## Test plan
- Release reset with `afilter_sw`=0 and run 400 samples:
  - one `cfg_load` 3 clk after reset release, then `gain` 0 for 256 samples;
  - then a ramp of 8/sample to 256; `busy` falls.
- In `IDLE`, set `afilter_sw`=4 with `audio_in_l`=16'h4000:
  - after 64 samples the fade-out starts, `audio_out_l` stepping 16'h4000→16'h3E00→…→0;
  - `flt_sel`=4, `cfg_load` pulse 3 clk later.
- Toggle `afilter_sw` 0→3→0 within 10 samples: no sequence, `gain` stays 256, no `cfg_load`.
- `afilter_sw`=2, then change to 6 during `SETTLE`: sequence completes with `flt_sel`=2, then re-triggers, ending at `flt_sel`=6 with two `cfg_load` pulses total.
- Change the request mid-`FADE_IN` at `gain`=128: `FADE_OUT` starts from 128 (next value 120), with no jump to 256.
- Assert `reset` during `FADE_OUT` at `gain`=96: all outputs go to their reset values asynchronously, and the sequence restarts from `SWITCH` after release.
